// File: rtl/register_file_32x32_sync_if.sv
// register_file_32x32_sync_if
//   Bus between a datapath controller and the register file.
//   master: drives read, write, addr_r1, addr_r2, addr_w and data_w.
//           Receives data_r1, data_r2 and r_valid.
//   slave : the register file, with the directions reversed.
//
// Handshake: there is no backpressure.
//   - The master raises read for one clock edge to capture both read ports.
//   - r_valid is high for exactly the following cycle.
//   - data_r1/data_r2 are meaningful while r_valid is high, and hold their
//     value otherwise.
//   - write commits data_w to addr_w on the edge at which it is sampled.
interface register_file_32x32_sync_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] addr_r1;
  logic [ADDR_WIDTH-1:0] addr_r2;
  logic [ADDR_WIDTH-1:0] addr_w;
  logic [DATA_WIDTH-1:0] data_w;
  logic [DATA_WIDTH-1:0] data_r1;
  logic [DATA_WIDTH-1:0] data_r2;
  logic                  r_valid;

  modport master (
    output read, write, addr_r1, addr_r2, addr_w, data_w,
    input  data_r1, data_r2, r_valid
  );

  modport slave (
    input  read, write, addr_r1, addr_r2, addr_w, data_w,
    output data_r1, data_r2, r_valid
  );
endinterface

// File: rtl/register_file_32x32_sync.sv
// register_file_32x32_sync
//   A 32 x 32-bit register file with one write port and two registered
//   read ports. It supplies operands A and B to the ALU.
//
// Ports
//   clk : rising-edge clock.
//   rst : synchronous, active-high reset. It clears the array, both read
//         outputs and r_valid, and overrides read and write in that cycle.
//   bus : register_file_32x32_sync_if.slave. It carries the read/write
//         strobes, the three addresses, write data, both read data outputs
//         and r_valid.
//
// Parameters
//   DATA_WIDTH : register width.
//   ADDR_WIDTH : address width; the file holds 2**ADDR_WIDTH registers.
//   ZERO_REG   : when nonzero, register 0 reads as 0 and ignores writes.
module register_file_32x32_sync #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input logic                      clk,
  input logic                      rst,
  register_file_32x32_sync_if.slave bus
);

  localparam int NREGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0]      wr_en;
  logic [DATA_WIDTH-1:0] rd1_mux;
  logic [DATA_WIDTH-1:0] rd2_mux;

  // One-hot write decoder gated by the write strobe.
  // With ZERO_REG set, row 0 never gets a load enable.
  always_comb begin
    wr_en = '0;
    if (bus.write) begin
      wr_en[bus.addr_w] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      wr_en[0] = 1'b0;
    end
  end

  // Storage: one row of flops per register, each with its own load enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_en[i]) begin
          regs[i] <= bus.data_w;
        end
      end
    end
  end

  // Read-select muxes, one per port.
  // They read the array contents from before the current edge, so a read
  // that coincides with a write to the same address returns the old value.
  // Address 0 is forced to zero explicitly as well. This covers the case
  // where register 0 was never reset after power-up.
  always_comb begin
    rd1_mux = regs[bus.addr_r1];
    rd2_mux = regs[bus.addr_r2];
    if (ZERO_REG != 0) begin
      if (bus.addr_r1 == '0) rd1_mux = '0;
      if (bus.addr_r2 == '0) rd2_mux = '0;
    end
  end

  // Output registers. They capture on read and hold otherwise.
  // r_valid marks the cycle after each capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data_r1 <= '0;
      bus.data_r2 <= '0;
      bus.r_valid <= 1'b0;
    end else begin
      bus.r_valid <= bus.read;
      if (bus.read) begin
        bus.data_r1 <= rd1_mux;
        bus.data_r2 <= rd2_mux;
      end
    end
  end

endmodule

// File: tb/tb_register_file_32x32_sync.sv
// tb_register_file_32x32_sync
//   Drives two register files with identical stimulus: dut_a (ZERO_REG=1)
//   and dut_b (ZERO_REG=0).
//   Each read request pushes the expected {data_r1, data_r2} pair for each
//   instance into that instance's queue. A monitor pops and compares the
//   pair whenever r_valid is seen. Reset and hold behaviour are checked
//   directly after the relevant edges.
module tb_register_file_32x32_sync;

  localparam int DW = 32;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  register_file_32x32_sync_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
  register_file_32x32_sync_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

  // dut_b mirrors every input of dut_a.
  assign bus_b.read    = bus_a.read;
  assign bus_b.write   = bus_a.write;
  assign bus_b.addr_r1 = bus_a.addr_r1;
  assign bus_b.addr_r2 = bus_a.addr_r2;
  assign bus_b.addr_w  = bus_a.addr_w;
  assign bus_b.data_w  = bus_a.data_w;

  register_file_32x32_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  register_file_32x32_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  // ---------------- scoreboard ----------------
  logic [2*DW-1:0] exp_a_q[$];
  logic [2*DW-1:0] exp_b_q[$];
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    logic [2*DW-1:0] e;
    if (bus_a.r_valid === 1'b1) begin
      if (exp_a_q.size() == 0) begin
        check("a_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_a_q.pop_front();
        check("a_data_r1", bus_a.data_r1, e[2*DW-1:DW]);
        check("a_data_r2", bus_a.data_r2, e[DW-1:0]);
      end
    end
    if (bus_b.r_valid === 1'b1) begin
      if (exp_b_q.size() == 0) begin
        check("b_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_b_q.pop_front();
        check("b_data_r1", bus_b.data_r1, e[2*DW-1:DW]);
        check("b_data_r2", bus_b.data_r2, e[DW-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One clock cycle of stimulus. Inputs change #1 after the rising edge.
  task automatic cycle(input logic r, input logic rd, input logic wr,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [AW-1:0] aw, input logic [DW-1:0] dw,
                       input logic [2*DW-1:0] ea, input logic [2*DW-1:0] eb);
    rst           = r;
    bus_a.read    = rd;
    bus_a.write   = wr;
    bus_a.addr_r1 = a1;
    bus_a.addr_r2 = a2;
    bus_a.addr_w  = aw;
    bus_a.data_w  = dw;
    if (rd && !r) begin
      exp_a_q.push_back(ea);
      exp_b_q.push_back(eb);
    end
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus_a.read  = 1'b0;
    bus_a.write = 1'b0;
  endtask

  task automatic wr_reg(input logic [AW-1:0] aw, input logic [DW-1:0] dw);
    cycle(1'b0, 1'b0, 1'b1, '0, '0, aw, dw, '0, '0);
  endtask

  task automatic rd_reg(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    cycle(1'b0, 1'b1, 1'b0, a1, a2, '0, '0, {e1, e2}, {e1, e2});
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_r_valid"}, {31'd0, bus_a.r_valid}, 32'd0);
    check({tag, "_a_data_r1"}, bus_a.data_r1, 32'd0);
    check({tag, "_a_data_r2"}, bus_a.data_r2, 32'd0);
    check({tag, "_b_r_valid"}, {31'd0, bus_b.r_valid}, 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [DW-1:0] v1, v2;
    rst = 1'b0;
    bus_a.read = 1'b0;
    bus_a.write = 1'b0;
    bus_a.addr_r1 = '0;
    bus_a.addr_r2 = '0;
    bus_a.addr_w = '0;
    bus_a.data_w = '0;
    @(posedge clk);
    #1;

    // Power-up reset.
    cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0);
    check_reset_outputs("init_rst");

    // Reset test: fill every register with ones.
    // Then read once, so that r_valid and the outputs are nonzero.
    for (int i = 0; i < 32; i++) wr_reg(i[AW-1:0], 32'hFFFF_FFFF);
    rd_reg(5'd3, 5'd30, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    // Reset with read requested: the read is ignored and everything clears.
    cycle(1'b1, 1'b1, 1'b0, 5'd3, 5'd3, '0, '0, '0, '0);
    check_reset_outputs("rst_cycle");
    idle();
    check_reset_outputs("after_rst");
    for (int i = 1; i < 32; i++) rd_reg(i[AW-1:0], i[AW-1:0], 32'd0, 32'd0);

    // Sweep: reg[i] = i * 0x01010101.
    for (int i = 1; i < 32; i++) wr_reg(i[AW-1:0], i * 32'h0101_0101);
    for (int i = 1; i < 32; i++) begin
      v1 = i * 32'h0101_0101;
      v2 = (31 - i) * 32'h0101_0101;
      rd_reg(i[AW-1:0], 5'(31 - i), v1, v2);
    end

    // Zero register: dut_a discards the write, dut_b keeps it.
    wr_reg(5'd0, 32'hDEAD_BEEF);
    cycle(1'b0, 1'b1, 1'b0, 5'd0, 5'd31, '0, '0,
          {32'h0000_0000, 32'h1F1F_1F1F}, {32'hDEAD_BEEF, 32'h1F1F_1F1F});
    cycle(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, '0, '0,
          {32'h0000_0000, 32'h0000_0000}, {32'hDEAD_BEEF, 32'hDEAD_BEEF});

    // Read-during-write returns the old value; the next read sees the new one.
    wr_reg(5'd5, 32'h1111_1111);
    cycle(1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 32'h2222_2222,
          {32'h1111_1111, 32'h1111_1111}, {32'h1111_1111, 32'h1111_1111});
    rd_reg(5'd5, 5'd6, 32'h2222_2222, 32'h0606_0606);

    // Hold: outputs keep their value while writes happen and read is low.
    wr_reg(5'd7, 32'h0000_ABCD);
    rd_reg(5'd7, 5'd7, 32'h0000_ABCD, 32'h0000_ABCD);
    for (int i = 0; i < 3; i++) begin
      wr_reg(5'd7, 32'h1234_5678);
      check("hold_a_data_r1", bus_a.data_r1, 32'h0000_ABCD);
      check("hold_a_data_r2", bus_a.data_r2, 32'h0000_ABCD);
      check("hold_a_r_valid", {31'd0, bus_a.r_valid}, 32'd0);
    end
    rd_reg(5'd7, 5'd1, 32'h1234_5678, 32'h0101_0101);

    // Reset with a pending write: the write is lost.
    wr_reg(5'd9, 32'h0000_0009);
    rd_reg(5'd9, 5'd9, 32'h0000_0009, 32'h0000_0009);
    cycle(1'b1, 1'b0, 1'b1, '0, '0, 5'd9, 32'hCAFE_F00D, '0, '0);
    check_reset_outputs("rst_wr");
    rd_reg(5'd9, 5'd9, 32'h0000_0000, 32'h0000_0000);
    rd_reg(5'd9, 5'd0, 32'h0000_0000, 32'h0000_0000);

    // Drain, then confirm every expected response was seen.
    repeat (3) idle();
    check("a_queue_left", exp_a_q.size(), 32'd0);
    check("b_queue_left", exp_b_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
